// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier: one multiplier bit per RUN cycle, LSB first.
// Signed operands are multiplied as magnitudes; the product is negated at the end when needed.
module shift_add_mult #(
  parameter int WIDTH       = 16,
  parameter int SIGNED_MODE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   mcand_reg, mcand_next;
  logic [PW-1:0]   acc_reg, acc_next;
  logic [PW-1:0]   out_reg, out_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            neg_reg, neg_next;

  logic            a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]   prod_sum, prod_final;

  // The magnitude of the most-negative value still fits in WIDTH unsigned bits.
  assign a_neg = (SIGNED_MODE != 0) && a[WIDTH-1];
  assign b_neg = (SIGNED_MODE != 0) && b[WIDTH-1];
  assign a_mag = a_neg ? (~a + WIDTH'(1)) : a;
  assign b_mag = b_neg ? (~b + WIDTH'(1)) : b;

  assign prod_sum   = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign prod_final = neg_reg ? (PW'(0) - prod_sum) : prod_sum;

  always_comb begin
    state_next  = state_reg;
    mcand_next  = mcand_reg;
    acc_next    = acc_reg;
    out_next    = out_reg;
    mplier_next = mplier_reg;
    cnt_next    = cnt_reg;
    neg_next    = neg_reg;
    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start) begin
          state_next  = RUN;
          mcand_next  = PW'(a_mag);
          mplier_next = b_mag;
          acc_next    = '0;
          cnt_next    = '0;
          neg_next    = a_neg ^ b_neg;
        end
      end
      RUN: begin
        acc_next    = prod_sum;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + CW'(1);
        // The last bit is folded straight into out on the edge that enters DONE.
        if (cnt_reg == CW'(WIDTH - 1)) begin
          state_next = DONE;
          out_next   = prod_final;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      acc_reg    <= '0;
      out_reg    <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      neg_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mcand_reg  <= mcand_next;
      acc_reg    <= acc_next;
      out_reg    <= out_next;
      mplier_reg <= mplier_next;
      cnt_reg    <= cnt_next;
      neg_reg    <= neg_next;
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign out  = out_reg;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed vector table plus hand-written corner sequences for shift_add_mult,
// with a width/mode sweep checked against a native-multiply reference.
module tb_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start16 [2];
  logic [15:0] a16 [2];
  logic [15:0] b16 [2];
  logic        busy16 [2];
  logic        done16 [2];
  logic [31:0] out16 [2];

  logic        start_sw = 1'b0;
  logic [31:0] a_sw = '0;
  logic [31:0] b_sw = '0;
  logic        busy_sw [6];
  logic        done_sw [6];
  logic [63:0] out_sw [6];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_add_mult #(.WIDTH(16), .SIGNED_MODE(0)) u_u16 (
    .clk(clk), .rst_n(rst_n), .start(start16[0]), .a(a16[0]), .b(b16[0]),
    .busy(busy16[0]), .done(done16[0]), .out(out16[0]));

  shift_add_mult #(.WIDTH(16), .SIGNED_MODE(1)) u_s16 (
    .clk(clk), .rst_n(rst_n), .start(start16[1]), .a(a16[1]), .b(b16[1]),
    .busy(busy16[1]), .done(done16[1]), .out(out16[1]));

  for (genvar gi = 0; gi < 6; gi++) begin : g_sw
    localparam int W = (gi < 2) ? 2 : ((gi < 4) ? 8 : 32);
    logic [2*W-1:0] o;
    shift_add_mult #(.WIDTH(W), .SIGNED_MODE(gi % 2)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_sw), .a(a_sw[W-1:0]), .b(b_sw[W-1:0]),
      .busy(busy_sw[gi]), .done(done_sw[gi]), .out(o));
    assign out_sw[gi] = 64'(o);
  end

  typedef struct {
    bit          sel;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int wof(input int i);
    return (i < 2) ? 2 : ((i < 4) ? 8 : 32);
  endfunction

  function automatic logic [63:0] ref_prod(input int w, input bit s, input logic [31:0] av, input logic [31:0] bv);
    longint sa, sb, p;
    logic [31:0] m;
    m = (w == 32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
    if (s) begin
      sa = $signed({av, 32'b0} << (32 - w)) >>> (64 - w);
      sb = $signed({bv, 32'b0} << (32 - w)) >>> (64 - w);
    end else begin
      sa = longint'({32'b0, av & m});
      sb = longint'({32'b0, bv & m});
    end
    p = sa * sb;
    if (w == 32) return p;
    return p & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // One multiply on a 16-bit DUT; optionally pulses start with new operands mid-RUN.
  task automatic run_mul(input bit sel, input logic [15:0] av, input logic [15:0] bv,
                         input logic [31:0] exp, input bit mid, input string nm);
    int first_done = 0;
    int n_done = 0;
    int n_busy = 0;
    logic [31:0] prev, got;
    bit hold_ok = 1'b1;
    got = '0;
    @(posedge clk); #1;
    prev = out16[sel];
    start16[sel] = 1'b1; a16[sel] = av; b16[sel] = bv;
    @(posedge clk); #1;
    start16[sel] = 1'b0; a16[sel] = 16'($urandom); b16[sel] = 16'($urandom);
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (mid && n == 5) begin start16[sel] = 1'b1; a16[sel] = 16'hffff; b16[sel] = 16'hffff; end
      if (mid && n == 6) start16[sel] = 1'b0;
      if (busy16[sel]) n_busy++;
      if (done16[sel]) begin
        n_done++;
        if (first_done == 0) begin first_done = n; got = out16[sel]; end
      end else if (first_done == 0 && out16[sel] !== prev) hold_ok = 1'b0;
    end
    check({nm, " out"}, 64'(got), 64'(exp));
    check({nm, " latency"}, 64'(first_done - 1), 64'd16);
    check({nm, " busy_cycles"}, 64'(n_busy), 64'd16);
    check({nm, " done_pulses"}, 64'(n_done), 64'd1);
    check({nm, " out_hold"}, 64'(hold_ok), 64'd1);
  endtask

  task automatic sweep_once(input int iter);
    int first_done [6];
    int n_busy [6];
    logic [63:0] got [6];
    for (int i = 0; i < 6; i++) begin first_done[i] = 0; n_busy[i] = 0; got[i] = '0; end
    @(posedge clk); #1;
    start_sw = 1'b1; a_sw = $urandom; b_sw = $urandom;
    if (iter == 0) begin a_sw = 32'h8000_0002; b_sw = 32'h8000_0082; end
    @(posedge clk); #1;
    start_sw = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
        if (busy_sw[i]) n_busy[i]++;
        if (done_sw[i] && first_done[i] == 0) begin first_done[i] = n; got[i] = out_sw[i]; end
      end
    end
    for (int i = 0; i < 6; i++) begin
      $display("[TB] sweep w=%0d s=%0d a=%h b=%h out=%h", wof(i), i % 2, a_sw, b_sw, got[i]);
      check($sformatf("sweep w%0d s%0d out", wof(i), i % 2), got[i], ref_prod(wof(i), (i % 2) == 1, a_sw, b_sw));
      check($sformatf("sweep w%0d s%0d latency", wof(i), i % 2), 64'(first_done[i] - 1), 64'(wof(i)));
      check($sformatf("sweep w%0d s%0d busy", wof(i), i % 2), 64'(n_busy[i]), 64'(wof(i)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt [10];
    int d1, d2;
    logic [31:0] o1, o2;
    logic b18;

    vt[0] = '{0, 16'h7ff8, 16'h0072, 32'h0038fc70, "u_base"};
    vt[1] = '{1, 16'h8000, 16'h8000, 32'h40000000, "s_minmin"};
    vt[2] = '{1, 16'hffff, 16'h0003, 32'hfffffffd, "s_m1x3"};
    vt[3] = '{0, 16'h0000, 16'hffff, 32'h00000000, "u_zero"};
    vt[4] = '{0, 16'hffff, 16'hffff, 32'hfffe0001, "u_max"};
    vt[5] = '{1, 16'hffff, 16'hffff, 32'h00000001, "s_m1m1"};
    vt[6] = '{1, 16'h8000, 16'h0001, 32'hffff8000, "s_minx1"};
    vt[7] = '{1, 16'h7fff, 16'h8000, 32'hc0008000, "s_maxmin"};
    vt[8] = '{0, 16'h1234, 16'h0010, 32'h00012340, "u_shift"};
    vt[9] = '{1, 16'h0003, 16'hfffb, 32'hfffffff1, "s_3xm5"};

    for (int i = 0; i < 2; i++) begin start16[i] = 1'b0; a16[i] = '0; b16[i] = '0; end

    #3;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset busy%0d", i), 64'(busy16[i]), 64'd0);
      check($sformatf("reset done%0d", i), 64'(done16[i]), 64'd0);
      check($sformatf("reset out%0d", i), 64'(out16[i]), 64'd0);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_mul(vt[i].sel, vt[i].a, vt[i].b, vt[i].exp, 1'b0, vt[i].name);
      $display("[TB] vec %s a=%h b=%h exp=%h", vt[i].name, vt[i].a, vt[i].b, vt[i].exp);
    end

    // Start pulsed mid-RUN must be ignored.
    run_mul(0, 16'h7ff8, 16'h0072, 32'h0038fc70, 1'b1, "u_midstart");
    $display("[TB] mid-RUN start sequence");

    // Back-to-back: start held through DONE, second operands 3*5.
    @(posedge clk); #1;
    start16[0] = 1'b1; a16[0] = 16'h0000; b16[0] = 16'hffff;
    @(posedge clk); #1;
    a16[0] = 16'd3; b16[0] = 16'd5;
    d1 = 0; d2 = 0; o1 = '1; o2 = '1; b18 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 18) begin b18 = busy16[0]; start16[0] = 1'b0; end
      if (done16[0]) begin
        if (d1 == 0) begin d1 = n; o1 = out16[0]; end
        else if (d2 == 0) begin d2 = n; o2 = out16[0]; end
      end
    end
    $display("[TB] back-to-back d1=%0d o1=%h d2=%0d o2=%h", d1, o1, d2, o2);
    check("b2b first_out", 64'(o1), 64'd0);
    check("b2b first_latency", 64'(d1 - 1), 64'd16);
    check("b2b no_idle_busy", 64'(b18), 64'd1);
    check("b2b second_done", 64'(d2), 64'd34);
    check("b2b second_out", 64'(o2), 64'd15);

    // Reset five cycles into RUN.
    run_mul(0, 16'h0101, 16'h0101, 32'h00010201, 1'b0, "u_prereset");
    @(posedge clk); #1;
    start16[0] = 1'b1; a16[0] = 16'h7ff8; b16[0] = 16'h0072;
    @(posedge clk); #1;
    start16[0] = 1'b0;
    for (int n = 1; n <= 5; n++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid busy", 64'(busy16[0]), 64'd0);
    check("rst_mid done", 64'(done16[0]), 64'd0);
    check("rst_mid out", 64'(out16[0]), 64'd0);
    check("rst_mid s_out", 64'(out16[1]), 64'd0);
    $display("[TB] reset mid-RUN sequence");
    @(negedge clk);
    rst_n = 1'b1;
    run_mul(0, 16'd3, 16'd5, 32'd15, 1'b0, "u_after_reset");

    for (int it = 0; it < 8; it++) sweep_once(it);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
